// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the 5-stage MIPS core.
// Rev 1.0
`default_nettype none
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } hzd_state_t;

  // A load in EX feeds a register the ID instruction reads; $zero never hazards.
  function automatic logic load_use(input logic     dren_ex,
                                    input regbits_t wsel_ex,
                                    input regbits_t rs_id,
                                    input regbits_t rt_id,
                                    input logic     uses_rt_id);
    return dren_ex && (wsel_ex != '0) &&
           ((wsel_ex == rs_id) || (uses_rt_id && (wsel_ex == rt_id)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: stall/flush event counter pair, wrapping modulo 2^CNT_W.
// Rev 1.0
`default_nettype none
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush control with load-use, cache-wait, redirect and halt handling.
// Rev 1.0
`default_nettype none
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemreq_mem,
  input  logic             dREN_ex,
  input  logic [4:0]       wsel_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             redirect_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzd_state_t state, next_state;

  logic lu;
  logic memwait;
  logic run_rules;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;
  logic stall_inc, flush_inc;

  assign lu = load_use(dREN_ex, wsel_ex, rs_id, rt_id, uses_rt_id);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALT);
    end
  end

  always_comb begin
    next_state    = state;
    run_rules     = 1'b0;
    memwait       = dmemreq_mem & ~dhit;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    flush_inc     = 1'b0;

    unique case (state)
      RUN:     run_rules = 1'b1;
      // Only dhit releases MEMWAIT; that cycle then behaves like RUN.
      MEMWAIT: begin
        run_rules = dhit;
        memwait   = 1'b0;
      end
      HALT:    run_rules = 1'b0;
      default: next_state = RUN;
    endcase

    if (run_rules) begin
      next_state = RUN;
      if (halt_wb) begin
        next_state = HALT;
      end else if (memwait) begin
        next_state = MEMWAIT;
      end else if (redirect_mem) begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        exmem_flush_c = 1'b1;
        flush_inc     = 1'b1;
      end else if (lu || !ihit) begin
        // Hold the front end and inject one bubble into ID/EX; the back end drains.
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        idex_flush_c = 1'b1;
      end else begin
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        idex_en_c  = 1'b1;
        exmem_en_c = 1'b1;
        memwb_en_c = 1'b1;
      end
    end
  end

  assign stall_inc = (state != HALT) && !pc_en_c;

  assign pc_en       = pc_en_c       & nRST;
  assign ifid_en     = ifid_en_c     & nRST;
  assign idex_en     = idex_en_c     & nRST;
  assign exmem_en    = exmem_en_c    & nRST;
  assign memwb_en    = memwb_en_c    & nRST;
  assign ifid_flush  = ifid_flush_c  & nRST;
  assign idex_flush  = idex_flush_c  & nRST;
  assign exmem_flush = exmem_flush_c & nRST;

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .CLK       (CLK),
    .nRST      (nRST),
    .stall_inc (stall_inc),
    .flush_inc (flush_inc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

endmodule
`default_nettype wire
